bus_arbiter_reg: RTL

//  Parametrised, registered successor to the datapath's combinational A/S-bus OR.

---
 rtl/bus_arbiter_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/bus_arbiter_reg.sv
// Registered multi-source bus merge: wired-OR or lowest-index priority, with
// optional output pipeline, hold-last-value and multi-driver conflict tracking.
module bus_arbiter_reg #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8,
  parameter int PIPE  = 1,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         src_en,
  input  logic                    prio_mode,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic [$clog2(NSRC)-1:0] bus_src,
  output logic                    conflict,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        conflict_cnt
);

  localparam int IDX_W = $clog2(NSRC);

  logic [WIDTH-1:0] or_data;
  logic [WIDTH-1:0] prio_data;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] next_out;
  logic [IDX_W-1:0] idx;
  logic             found;
  logic             any;
  logic             multi;

  always_comb begin
    or_data   = '0;
    prio_data = '0;
    idx       = '0;
    found     = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_en[i]) begin
        or_data = or_data | src_data[i*WIDTH +: WIDTH];
        if (!found) begin
          found     = 1'b1;
          idx       = IDX_W'(i);
          prio_data = src_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more enables are high.
  assign any      = |src_en;
  assign multi    = |(src_en & (src_en - NSRC'(1)));
  assign merged   = prio_mode ? prio_data : or_data;
  assign next_out = any ? merged : ((HOLD != 0) ? hold_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (any) begin
      hold_q <= merged;
    end
  end

  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bus_out   <= '0;
        bus_valid <= 1'b0;
        bus_src   <= '0;
      end else begin
        bus_out   <= next_out;
        bus_valid <= any;
        bus_src   <= idx;
      end
    end
  end else begin : g_comb
    assign bus_out   = next_out;
    assign bus_valid = any;
    assign bus_src   = idx;
  end

  // A conflict in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict     <= 1'b0;
      err_sticky   <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict <= multi;
      if (multi) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
      if (multi) begin
        if (err_clr) begin
          conflict_cnt <= CNT_W'(1);
        end else if (!(&conflict_cnt)) begin
          conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
      end else if (err_clr) begin
        conflict_cnt <= '0;
      end
    end
  end

endmodule
